// File: rtl/matmul_seq_scheduler.sv
// matmul_seq_scheduler: sequences an L x M by M x N matrix product through a
// shared external dot-product unit of latency LAT, one output element per clock.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          request a new multiplication (honoured in IDLE and DONE only)
//   A, B_T         operand matrices, row-major (B transposed), latched on accept
//   dot_res        scalar returned by the dot unit
//   vec_a, vec_b   operand rows presented to the dot unit (0 outside ISSUE)
//   busy, done     busy in ISSUE/DRAIN, one-cycle done pulse
//   result         row-major L x N result matrix
module matmul_seq_scheduler #(
    parameter int unsigned L   = 2,
    parameter int unsigned M   = 2,
    parameter int unsigned N   = 2,
    parameter int unsigned LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [32*L*M-1:0]     A,
    input  logic [32*N*M-1:0]     B_T,
    input  logic [31:0]           dot_res,
    output logic [32*M-1:0]       vec_a,
    output logic [32*M-1:0]       vec_b,
    output logic                  busy,
    output logic                  done,
    output logic [32*L*N-1:0]     result
);

    localparam int unsigned DW    = 32;
    localparam int unsigned ROW_W = DW * M;
    localparam int unsigned P     = L * N;
    localparam int unsigned I_W   = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned J_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IDX_W = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pipe_entry_t;

    state_t             state_q, state_d;
    logic [I_W-1:0]     i_q, i_d;
    logic [J_W-1:0]     j_q, j_d;
    logic [ROW_W-1:0]   a_rows [L];
    logic [ROW_W-1:0]   b_rows [N];
    logic [DW-1:0]      res_q  [P];
    logic               load;
    logic [ROW_W-1:0]   vec_a_d, vec_b_d;
    pipe_entry_t        push;
    pipe_entry_t        head;
    logic               last_pair;

    assign last_pair = (i_q == I_W'(L - 1)) && (j_q == J_W'(N - 1));

    // Next-state, index sequencing and next values of the registered outputs
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        load    = 1'b0;
        push    = '0;
        vec_a_d = '0;
        vec_b_d = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                push.valid = 1'b1;
                push.idx   = IDX_W'(N * i_q + j_q);
                if (last_pair) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = (LAT > 1) ? S_DRAIN : S_DONE;
                end else if (j_q == J_W'(N - 1)) begin
                    j_d = '0;
                    i_d = i_q + I_W'(1);
                end else begin
                    j_d = j_q + J_W'(1);
                end
            end
            S_DRAIN: begin
                if (head.valid && head.idx == IDX_W'(P - 1))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // Operand rows are registered one cycle ahead; on accept use the live inputs.
        if (state_d == S_ISSUE) begin
            if (load) begin
                vec_a_d = A[ROW_W-1:0];
                vec_b_d = B_T[ROW_W-1:0];
            end else begin
                vec_a_d = a_rows[i_d];
                vec_b_d = b_rows[j_d];
            end
        end
    end

    // Index pipeline: an entry pushed in cycle c is at the head in cycle c+LAT-1
    generate
        if (LAT == 1) begin : g_pipe_comb
            assign head = push;
        end else begin : g_pipe_reg
            pipe_entry_t pipe_q [LAT-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < int'(LAT) - 1; k++) pipe_q[k] <= '0;
                end else begin
                    pipe_q[0] <= push;
                    for (int k = 1; k < int'(LAT) - 1; k++) pipe_q[k] <= pipe_q[k-1];
                end
            end
            assign head = pipe_q[LAT-2];
        end
    endgenerate

    // State, counters, operand copies, outputs and result storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            vec_a   <= '0;
            vec_b   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int r = 0; r < int'(L); r++) a_rows[r] <= '0;
            for (int r = 0; r < int'(N); r++) b_rows[r] <= '0;
            for (int e = 0; e < int'(P); e++) res_q[e] <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            vec_a   <= vec_a_d;
            vec_b   <= vec_b_d;
            busy    <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
            done    <= (state_d == S_DONE);
            if (load) begin
                for (int r = 0; r < int'(L); r++) a_rows[r] <= A[r*ROW_W +: ROW_W];
                for (int r = 0; r < int'(N); r++) b_rows[r] <= B_T[r*ROW_W +: ROW_W];
            end
            if (head.valid)
                res_q[head.idx] <= dot_res;
        end
    end

    // Flatten result storage onto the row-major output bus
    generate
        for (genvar e = 0; e < int'(P); e++) begin : g_result
            assign result[DW*e +: DW] = res_q[e];
        end
    endgenerate

endmodule

// File: tb/tb_matmul_seq_scheduler.sv
// Testbench for matmul_seq_scheduler: a LAT=1 instance (2x2 by 2x1, combinational
// dot model) and a LAT=3 instance (2x2 by 2x2, two-register dot model).
module tb_matmul_seq_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // LAT=1 instance: L=2 M=2 N=1
    logic         start1 = 1'b0;
    logic [127:0] a1 = '0;
    logic [63:0]  b1 = '0;
    logic [31:0]  dot1;
    logic [63:0]  vec_a1, vec_b1;
    logic         busy1, done1;
    logic [63:0]  res1;

    // LAT=3 instance: L=2 M=2 N=2
    logic         start3 = 1'b0;
    logic [127:0] a3 = '0;
    logic [127:0] b3 = '0;
    logic [31:0]  dot3, d1, d2;
    logic [63:0]  vec_a3, vec_b3;
    logic         busy3, done3;
    logic [127:0] res3;

    matmul_seq_scheduler #(.L(2), .M(2), .N(1), .LAT(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B_T(b1), .dot_res(dot1),
        .vec_a(vec_a1), .vec_b(vec_b1), .busy(busy1), .done(done1), .result(res1)
    );

    matmul_seq_scheduler #(.L(2), .M(2), .N(2), .LAT(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .A(a3), .B_T(b3), .dot_res(dot3),
        .vec_a(vec_a3), .vec_b(vec_b3), .busy(busy3), .done(done3), .result(res3)
    );

    function automatic logic [31:0] dot2(input logic [63:0] x, input logic [63:0] y);
        return x[31:0] * y[31:0] + x[63:32] * y[63:32];
    endfunction

    assign dot1 = dot2(vec_a1, vec_b1);

    // Two-register dot unit: result of cycle c appears in cycle c+2
    always @(posedge clk) begin
        d1 <= dot2(vec_a3, vec_b3);
        d2 <= d1;
    end
    assign dot3 = d2;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] a;
        logic [63:0]  b;
        logic [63:0]  r;
    } vec1_t;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] r;
    } vec3_t;

    vec1_t t1 [4];
    vec3_t t3 [3];

    // One LAT=1 operation: rows in cycles 0 and 1, done in cycle 2
    task automatic run1(input vec1_t v);
        int cyc;
        int busy_cnt;
        int done_cyc;
        @(negedge clk);
        a1 = v.a; b1 = v.b; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        busy_cnt = 0; done_cyc = -1;
        for (cyc = 0; cyc < 20; cyc++) begin
            if (busy1) busy_cnt++;
            if (cyc < 2) begin
                chk("u1_vec_a", 128'(vec_a1), 128'(v.a[64*cyc +: 64]));
                chk("u1_vec_b", 128'(vec_b1), 128'(v.b));
            end
            if (done1) begin
                done_cyc = cyc;
                chk("u1_vec_a_idle", 128'(vec_a1), 128'(0));
                break;
            end
            @(negedge clk);
        end
        chk("u1_done_cycle", 128'(done_cyc), 128'(2));
        chk("u1_busy_cycles", 128'(busy_cnt), 128'(2));
        chk("u1_result", 128'(res1), 128'(v.r));
    endtask

    // One LAT=3 operation with optional corner-case stimulus
    task automatic run3(input vec3_t v, input bit skip_start, input bit pulses,
                        input bit change_ops, input bit hold);
        int cyc;
        int busy_cnt;
        int done_cyc;
        if (!skip_start) begin
            @(negedge clk);
            a3 = v.a; b3 = v.b; start3 = 1'b1;
        end
        @(negedge clk);
        start3 = hold;
        busy_cnt = 0; done_cyc = -1;
        for (cyc = 0; cyc < 20; cyc++) begin
            if (busy3) busy_cnt++;
            if (cyc < 4) begin
                chk("u3_vec_a", 128'(vec_a3), 128'(v.a[64*(cyc/2) +: 64]));
                chk("u3_vec_b", 128'(vec_b3), 128'(v.b[64*(cyc%2) +: 64]));
            end else begin
                chk("u3_vec_zero", 128'({vec_a3, vec_b3}), 128'(0));
            end
            if (done3) begin
                done_cyc = cyc;
                break;
            end
            if (pulses) start3 = (cyc == 1 || cyc == 3);
            if (change_ops && cyc == 1) begin
                a3 = '1; b3 = '1;
            end
            @(negedge clk);
        end
        chk("u3_done_cycle", 128'(done_cyc), 128'(6));
        chk("u3_busy_cycles", 128'(busy_cnt), 128'(6));
        chk("u3_result", res3, v.r);
    endtask

    initial begin
        int done_seen;
        t1[0] = '{a: {32'd4, 32'd3, 32'd2, 32'd1}, b: {32'd6, 32'd5}, r: {32'd39, 32'd17}};
        t1[1] = '{a: '0, b: {32'd9, 32'd7}, r: '0};
        t1[2] = '{a: {32'd3, 32'd2, 32'd1, 32'hFFFFFFFF}, b: {32'd1, 32'd1}, r: {32'd5, 32'd0}};
        t1[3] = '{a: {32'd100, 32'd0, 32'd0, 32'd100}, b: {32'd4, 32'd3}, r: {32'd400, 32'd300}};

        t3[0] = '{a: {32'd4, 32'd3, 32'd2, 32'd1}, b: {32'd8, 32'd7, 32'd6, 32'd5},
                  r: {32'd53, 32'd39, 32'd23, 32'd17}};
        t3[1] = '{a: {32'd3, 32'd0, 32'd0, 32'd2}, b: {32'd5, 32'd2, 32'd1, 32'd1},
                  r: {32'd15, 32'd3, 32'd4, 32'd2}};
        t3[2] = '{a: {32'd1, 32'd1, 32'd1, 32'd1},
                  b: {32'h10000, 32'h1000, 32'h100, 32'h10},
                  r: {32'h11000, 32'h110, 32'h11000, 32'h110}};

        repeat (3) @(negedge clk);
        chk("rst_u1_outputs", 128'({busy1, done1, vec_a1, vec_b1}), 128'(0));
        chk("rst_u1_result", 128'(res1), 128'(0));
        chk("rst_u3_outputs", 128'({busy3, done3, vec_a3, vec_b3}), 128'(0));
        chk("rst_u3_result", res3, 128'(0));
        rst = 1'b0;

        for (int k = 0; k < 4; k++) run1(t1[k]);
        for (int k = 0; k < 3; k++) run3(t3[k], 1'b0, 1'b0, 1'b0, 1'b0);

        // start pulses during the operation are ignored
        run3(t3[0], 1'b0, 1'b1, 1'b0, 1'b0);
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done3) done_seen++;
        end
        chk("ignored_start_no_done", 128'(done_seen), 128'(0));

        // operands changed after the start cycle do not affect the result
        run3(t3[1], 1'b0, 1'b0, 1'b1, 1'b0);

        // start held through DONE: second operation follows back-to-back
        run3(t3[2], 1'b0, 1'b0, 1'b0, 1'b1);
        run3(t3[2], 1'b1, 1'b0, 1'b0, 1'b0);

        // reset in cycle 1 abandons the operation
        @(negedge clk);
        a3 = t3[0].a; b3 = t3[0].b; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", 128'({busy3, done3, vec_a3, vec_b3}), 128'(0));
        chk("rst_mid_result", res3, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done3 || busy3) done_seen++;
        end
        chk("rst_mid_no_done", 128'(done_seen), 128'(0));
        run3(t3[0], 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
